// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial binary-to-BCD converter:
//   DIGIT_W     - width of one BCD digit
//   state_t     - converter FSM states (IDLE, SHIFT, DONE)
//   min_digits  - smallest digit count able to hold 2^bin_w - 1 in decimal
// ----------------------------------------------------------------------------
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counts the decimal digits of the largest BIN_W-bit operand.
  function automatic int min_digits(input int bin_w);
    longint unsigned max_v;
    int              n;
    max_v = (bin_w >= 64) ? '1 : ((64'd1 << bin_w) - 64'd1);
    n     = 1;
    max_v = max_v / 10;
    while (max_v != 0) begin
      n     = n + 1;
      max_v = max_v / 10;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// ----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational add-3 correction for one BCD digit ahead of the left shift:
// a digit of 5..9 would become >= 10 after doubling, so 3 is added first.
// Ports:
//   d_in  - accumulator digit before the shift
//   d_out - corrected digit
// ----------------------------------------------------------------------------
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] d_out
);

  always_comb begin
    d_out = d_in;
    if (d_in >= DIGIT_W'(5)) begin
      d_out = d_in + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_serial.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_serial
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
// with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake, bin_in is the unsigned operand
//   out_valid/out_ready - result handshake, bcd_out is packed BCD (digit 0 =
//                         bits [3:0])
//   busy                - high while converting or holding a result
//   lz_mask             - leading-zero mask, present only when the macro
//                         BIN2BCD_LZ_EN is defined
// ----------------------------------------------------------------------------
module bin_to_bcd_serial
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIN_W-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      busy
`ifdef BIN2BCD_LZ_EN
  ,
  output logic [DIGITS-1:0]         lz_mask
`endif
);

  localparam int ACC_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
    $error("bin_to_bcd_serial: DIGITS too small for BIN_W");
  end

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   opnd_q, opnd_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   bcd_q, bcd_d;
  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   acc_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_in  (acc_q[g*DIGIT_W +: DIGIT_W]),
      .d_out (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Next operand bit enters the units LSB; the bit leaving the top digit is
  // always zero because DIGITS covers the full operand range.
  assign acc_shift = ACC_W'({adj, opnd_q[BIN_W-1]});

  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d  = bin_in;
          acc_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        acc_d  = acc_shift;
        opnd_d = opnd_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = acc_shift;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign bcd_out   = bcd_q;

`ifdef BIN2BCD_LZ_EN
  logic [DIGITS-1:0] lz_q, lz_d, lz_next;
  logic              hi_zero;

  // Bit i is set when digit i and every digit above it are zero; the units
  // digit is never blanked.
  always_comb begin
    lz_next = '0;
    hi_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero    = hi_zero && (acc_shift[i*DIGIT_W +: DIGIT_W] == '0);
      lz_next[i] = hi_zero;
    end
  end

  always_comb begin
    lz_d = lz_q;
    if ((state_q == SHIFT) && (cnt_q == CNT_W'(1))) begin
      lz_d = lz_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lz_q <= '0;
    end else begin
      lz_q <= lz_d;
    end
  end

  assign lz_mask = lz_q;
`endif

endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
- Sequential binary-to-BCD converter using the shift-and-add-3 method, one bit per clock.
- Sits directly upstream of the BCD-to-Excess-3 converter: each 4-bit slice of bcd_out feeds one converter instance (digit MSB..LSB onto the converter's A,B,C,D inputs).
- Valid/ready handshake on both input and output sides, so it can sit between a binary producer (counter, ALU result) and the code-conversion/display stages.

Parameters:
- BIN_W, 8, width of the binary input.
- DIGITS, 3, number of BCD output digits. Elaboration error if 10^DIGITS - 1 < 2^BIN_W - 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  bin_in is valid
- in_ready  output  1  block can accept an operand
- bin_in  input  BIN_W  unsigned binary operand
- out_valid  output  1  bcd_out holds a finished result
- out_ready  input  1  consumer takes the result
- bcd_out  output  4*DIGITS  packed BCD, digit 0 = bits [3:0] (units)
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Only one clock domain (clk). rst_n asserts asynchronously and deasserts as the design's reset release.
- While rst_n is low, registered state is cleared:
  - state=IDLE, shift register=0, bit counter=0, bcd_out=0, out_valid=0, busy=0.
  - in_ready is decoded from IDLE, so it reads 1.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge (the accept edge):
    - load the operand register with bin_in;
    - clear the BCD accumulator;
    - load the counter with BIN_W;
    - go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid and bin_in are ignored.
  - Each cycle:
    - every accumulator digit >= 5 gets +3 (digits >9 never occur);
    - then {accumulator, operand} shifts left by 1;
    - counter decrements.
  - When the counter reaches 1 and that shift completes, go to DONE.
- DONE:
  - out_valid=1; bcd_out is held stable until the handshake.
  - On out_valid & out_ready at an edge, go to IDLE and drop out_valid.
  - No new operand is accepted in the same cycle as result pop. Throughput is one result per BIN_W+2 cycles minimum.
- Latency: out_valid rises exactly BIN_W clock edges after the accept edge (8 for the default parameters).
- bcd_out is updated only on the final SHIFT edge.
  - It keeps its last value in IDLE.
  - It is 0 after reset.
- Arithmetic rules:
  - All digit adjust is 4-bit unsigned; carries out of a digit go only to the next digit's LSB via the shift.
  - The shift out of the top digit is discarded, which is guaranteed zero by the parameter check.
- Boundary conditions:
  - bin_in = 0 gives an all-zero result.
  - bin_in = 2^BIN_W-1 gives the exact decimal value.
  - out_ready held low keeps the block in DONE indefinitely with bcd_out constant.
  - rst_n asserted mid-SHIFT or mid-DONE aborts the operation: no partial result, out_valid=0 immediately.
  - in_valid held high continuously is accepted once per IDLE visit only.

Optional Feature:
- Macro BIN2BCD_LZ_EN.
- When defined:
  - add output port lz_mask [DIGITS-1:0], registered and updated with bcd_out.
  - bit i=1 if digit i and all higher digits are zero; bit 0 is always 0, so the units digit is never blanked.
  - reset value: all zeros.
- When undefined, the port and its logic are absent and the behaviour is otherwise identical.

Decomposition:
- Package bcd_pkg:
  - DIGIT_W=4 constant;
  - state enum {IDLE, SHIFT, DONE};
  - a function that computes the minimum DIGITS for a given BIN_W, used by the elaboration check.
- Sub-module bcd_digit_adjust: combinational 4-bit in/out implementing "+3 if >=5", instantiated DIGITS times in a generate loop.
- FSM, counter and shift register stay in the top module.

Test Plan:
- Reset release, then bin_in=0 with in_valid for 1 cycle -> out_valid after 8 edges, bcd_out=12'h000; with LZ_EN, lz_mask=3'b110.
- bin_in=8'd255 -> bcd_out=12'h255 exactly 8 edges after accept; in_ready=0 and busy=1 throughout.
- bin_in=8'd99, out_ready held low 5 cycles -> bcd_out=12'h099 stable, out_valid high for all 5 cycles; pops on the cycle out_ready=1, then in_ready=1 the next cycle.
- in_valid held high with bin_in changing 8'd7 -> 8'd200 during SHIFT -> result is 12'h007 (first operand only); the next accept after the pop yields 12'h200.
- rst_n pulsed low at the 4th SHIFT cycle of bin_in=8'd123 -> out_valid=0 and bcd_out=0 immediately (asynchronous); no result is emitted; a following bin_in=8'd123 gives 12'h123.
- Sweep all 256 inputs back-to-back with out_ready=1 -> every bcd_out matches the decimal value, and each digit <= 9 so it is legal for the downstream converter.
